uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side byte buffer sitting directly upstream of `uart_tx`. It accepts bytes from the system side, stores them in a circular FIFO, and launches them one at a time into `uart_tx` using its `data_rdy_in` / `tx_busy_out` / `tx_done_out` handshake. The system side can queue whole messages without tracking the serializer's state.

## Interface
Parameters:
- `DATA_BITS`, 8: byte width; must match `uart_tx` `DATA_BITS`.
- `DEPTH`, 16: FIFO entries; power of two, at least 2.

Ports:
- `sysclk_in`  in  1  system clock; the same clock as `uart_tx`.
- `rst_in`  in  1  synchronous active-high reset.
- `wr_en_in`  in  1  write strobe; one byte per cycle.
- `wr_data_in`  in  DATA_BITS  byte to queue.
- `full_out`  out  1  FIFO holds DEPTH entries.
- `empty_out`  out  1  FIFO holds 0 entries.
- `count_out`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow_out`  out  1  one-cycle pulse when a write is dropped.
- `tx_idle_out`  out  1  high when the FIFO is empty and the FSM is in IDLE (all queued bytes handed off and finished).
- `tx_data_out`  out  DATA_BITS  drives `uart_tx.tx_data_in`.
- `data_rdy_out`  out  1  drives `uart_tx.data_rdy_in`; one-cycle pulse.
- `tx_busy_in`  in  1  from `uart_tx.tx_busy_out`.
- `tx_done_in`  in  1  from `uart_tx.tx_done_out`.

## Operation
- All outputs are registered.
- Reset values:
  - `count_out`=0, `empty_out`=1, `full_out`=0
  - `overflow_out`=0, `data_rdy_out`=0, `tx_data_out`=0
  - `tx_idle_out`=1
  - read pointer and write pointer = 0, FSM in IDLE
- Storage:
  - `DEPTH` x `DATA_BITS` register array.
  - Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - Occupancy is held in a separate counter.
- Write:
  - When `wr_en_in`=1 and `full_out`=0 (registered value), the byte is stored at the write pointer and the write pointer increments.
  - When `wr_en_in`=1 and `full_out`=1, the byte is dropped and `overflow_out` pulses for 1 cycle. This holds even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: if `empty_out`=0 and `tx_busy_in`=0, load the head byte into `tx_data_out`, pulse `data_rdy_out`, increment the read pointer (pop), and go to WAIT_BUSY.
  - WAIT_BUSY: wait for `tx_busy_in`=1, then go to WAIT_DONE. `tx_data_out` is held.
  - WAIT_DONE: wait for `tx_done_in`=1, then go to IDLE. `tx_data_out` is held.
  - Any unused encoding returns to IDLE.
- Occupancy per cycle:
  - accepted write only: +1
  - pop only: -1
  - accepted write and pop together: unchanged
- Flags: `full_out` and `empty_out` are updated from the next-state count in the same edge as the count.
- Data path: `tx_data_out` changes only on a pop. It is stable from the `data_rdy_out` pulse until `tx_done_in`.
- Reset mid-transfer:
  - The FIFO contents are discarded and all pointers, count and FSM return to reset values.
  - `uart_tx` is reset by the same system reset, so no handshake is left dangling.

## Timing
- Launch latency into an empty, idle FIFO:
  - Write sampled at edge E0; `empty_out`=0 after E0.
  - `data_rdy_out`=1 for the cycle after E1.
  - `count_out` returns to 0 after E1.
- Back-to-back bytes:
  - `tx_done_in` sampled at edge Ed moves the FSM to IDLE.
  - The next `data_rdy_out` asserts after Ed+1, provided `tx_busy_in` has dropped.
- `uart_tx` raises `tx_busy_out` one edge after sampling `data_rdy_in`; WAIT_BUSY absorbs this latency.
- `data_rdy_out` is never high for two consecutive cycles.
- At most one byte is in flight.
- No combinational path from any input to any output.

## Test plan
- Reset, then 10 idle cycles:
  - `empty_out`=1, `tx_idle_out`=1, `count_out`=0.
  - `data_rdy_out` never asserts; serial line stays 1.
- Single write of 0xA5 into an idle FIFO, with `uart_tx` attached (OVERSAMPLING 8):
  - `data_rdy_out` pulses exactly 2 edges after the write.
  - The serial line shows start bit 0, then bits LSB-first 1,0,1,0,0,1,0,1, then stop bit 1.
  - `tx_idle_out` returns to 1 after `tx_done_in`.
- Burst of 16 writes 0x00..0x0F on consecutive cycles (DEPTH 16):
  - `full_out` never asserts, because the first byte pops early; no overflow.
  - The serial output order is 0x00..0x0F.
  - One `data_rdy_out` pulse per `tx_done_in`.
- 20 consecutive writes with the serializer stalled (`tx_busy_in` forced 1):
  - `full_out`=1 after the 16th accepted write.
  - Writes 17-20 each pulse `overflow_out`; `count_out` stays 16.
- Write and pop in the same cycle:
  - Trigger the pop from the IDLE state while `wr_en_in`=1 with `count_out`=3; `count_out` stays 3.
  - Repeat with `count_out` at 16 (full): the write is dropped and `count_out` becomes 15.
- Assert `rst_in` for one cycle during the data bits of the second of 4 queued bytes:
  - All outputs reach their reset values after that edge.
  - No further `data_rdy_out` pulses; the line returns to 1.
  - A fresh write of 0x3C transmits correctly.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Transmit byte buffer that sits directly in front of uart_tx. Bytes written on
// the system side are queued in a circular FIFO. They are launched one at a time
// into the serializer through its data_rdy / tx_busy / tx_done handshake.
//
// Ports
//   sysclk_in     system clock (shared with uart_tx)
//   rst_in        synchronous active-high reset
//   wr_en_in      write strobe, one byte per cycle
//   wr_data_in    byte to queue
//   full_out      FIFO holds DEPTH entries
//   empty_out     FIFO holds no entries
//   count_out     current occupancy
//   overflow_out  one-cycle pulse when a write is dropped
//   tx_idle_out   FIFO empty and no byte in flight
//   tx_data_out   byte presented to uart_tx
//   data_rdy_out  one-cycle launch pulse to uart_tx
//   tx_busy_in    uart_tx busy
//   tx_done_in    uart_tx finished a byte
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic                       sysclk_in,
  input  logic                       rst_in,
  input  logic                       wr_en_in,
  input  logic [DATA_BITS-1:0]       wr_data_in,
  output logic                       full_out,
  output logic                       empty_out,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       overflow_out,
  output logic                       tx_idle_out,
  output logic [DATA_BITS-1:0]       tx_data_out,
  output logic                       data_rdy_out,
  input  logic                       tx_busy_in,
  input  logic                       tx_done_in
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_BUSY = 2'b01,
    WAIT_DONE = 2'b10
  } state_t;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 overflow_q, overflow_d;
  logic                 idle_q, idle_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 rdy_q, rdy_d;
  state_t               state_q, state_d;
  logic                 wr_acc_s;
  logic                 pop_s;

  // Write acceptance uses the registered full flag, so a pop in the same
  // cycle never rescues a write that arrives while full.
  assign wr_acc_s = wr_en_in && !full_q;
  assign pop_s    = (state_q == IDLE) && !empty_q && !tx_busy_in;

  // Handshake FSM, pointers, occupancy and flags: next-state logic.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    rdy_d      = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = wr_en_in && full_q;

    case (state_q)
      IDLE: begin
        if (pop_s) begin
          tx_data_d = mem_q[rd_ptr_q];
          rdy_d     = 1'b1;
          rd_ptr_d  = rd_ptr_q + AW'(1);
          state_d   = WAIT_BUSY;
        end else begin
          state_d   = IDLE;
        end
      end
      // uart_tx raises busy one edge after sampling data_rdy; wait it out.
      WAIT_BUSY: begin
        if (tx_busy_in) begin
          state_d = WAIT_DONE;
        end else begin
          state_d = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (tx_done_in) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (wr_acc_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (!wr_acc_s && pop_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == CW'(0));
    idle_d  = empty_d && (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge sysclk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      idle_q     <= 1'b1;
      tx_data_q  <= '0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      idle_q     <= idle_d;
      tx_data_q  <= tx_data_d;
      rdy_q      <= rdy_d;
    end
  end

  // Storage array; contents need no reset because the pointers and count do.
  always_ff @(posedge sysclk_in) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q] <= wr_data_in;
    end
  end

  assign full_out     = full_q;
  assign empty_out    = empty_q;
  assign count_out    = count_q;
  assign overflow_out = overflow_q;
  assign tx_idle_out  = idle_q;
  assign tx_data_out  = tx_data_q;
  assign data_rdy_out = rdy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: behavioural queue model plus a simple serializer
// responder that mimics uart_tx handshake timing.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       busy = 1'b0;
  logic       done = 1'b0;
  logic       full, empty, ovf, idle, rdy;
  logic [4:0] cnt;
  logic [7:0] txd;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .DEPTH(DEPTH)) dut (
    .sysclk_in(clk), .rst_in(rst_in), .wr_en_in(wr_en), .wr_data_in(wr_data),
    .full_out(full), .empty_out(empty), .count_out(cnt), .overflow_out(ovf),
    .tx_idle_out(idle), .tx_data_out(txd), .data_rdy_out(rdy),
    .tx_busy_in(busy), .tx_done_in(done)
  );

  int tests = 0;
  int fails = 0;

  // behavioural model state
  logic [7:0] q[$];
  bit         in_flight = 0;
  bit         seen_busy = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_rdy = 0;
  bit         m_ovf = 0;

  // serializer responder state
  bit         stall = 0;
  int         resp = 0;
  int         len = 0;
  logic [7:0] rx[$];
  int         n_rdy = 0;
  int         n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the inputs the DUT just sampled to the queue model.
  task automatic model_step();
    bit pop, acc;
    if (rst_in) begin
      q.delete();
      in_flight = 0; seen_busy = 0; m_data = 8'h00; m_rdy = 0; m_ovf = 0;
    end else begin
      pop   = !in_flight && (q.size() > 0) && !busy;
      m_ovf = wr_en && (q.size() == DEPTH);
      acc   = wr_en && (q.size() < DEPTH);
      m_rdy = pop;
      if (pop) begin
        m_data = q.pop_front();
        in_flight = 1; seen_busy = 0;
      end else if (in_flight) begin
        if (!seen_busy) seen_busy = busy;
        else if (done) in_flight = 0;
      end
      if (acc) q.push_back(wr_data);
    end
  endtask

  task automatic compare_all();
    check("count", cnt, q.size());
    check("empty", empty, q.size() == 0);
    check("full", full, q.size() == DEPTH);
    check("overflow", ovf, m_ovf);
    check("data_rdy", rdy, m_rdy);
    check("tx_data", txd, m_data);
    check("tx_idle", idle, (q.size() == 0) && !in_flight);
  endtask

  // uart_tx stand-in: busy one edge after data_rdy, random duration, done pulse.
  task automatic responder();
    if (rdy === 1'b1) n_rdy++;
    if (rst_in) begin
      busy = 1'b0; done = 1'b0; resp = 0;
    end else if (stall) begin
      busy = 1'b1; done = 1'b0;
    end else begin
      case (resp)
        0: begin
          busy = 1'b0; done = 1'b0;
          if (rdy === 1'b1) begin rx.push_back(txd); resp = 1; end
        end
        1: begin busy = 1'b1; len = $urandom_range(1, 6); resp = 2; end
        2: begin
          if (len == 0) begin busy = 1'b0; done = 1'b1; n_done++; resp = 3; end
          else len--;
        end
        default: begin done = 1'b0; resp = 0; end
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    compare_all();
    responder();
  endtask

  task automatic drain();
    bit ok = 0;
    for (int k = 0; k < 3000; k++) begin
      if (idle === 1'b1 && resp == 0 && rdy === 1'b0 && !in_flight) begin ok = 1; break; end
      cycle();
    end
    check("drain_timeout", ok, 1);
  endtask

  initial begin
    bit fs, os, ok;
    int r0;
    // reset and idle
    rst_in = 1'b1; cycle(); rst_in = 1'b0;
    check("rst_count", cnt, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_idle", idle, 1);
    check("rst_rdy", rdy, 0);
    check("rst_txd", txd, 0);
    check("rst_ovf", ovf, 0);
    for (int i = 0; i < 10; i++) cycle();
    check("idle_no_rdy", n_rdy, 0);

    // single byte launch latency
    wr_en = 1'b1; wr_data = 8'hA5; cycle(); wr_en = 1'b0;
    check("e0_empty", empty, 0);
    check("e0_count", cnt, 1);
    check("e0_rdy", rdy, 0);
    cycle();
    check("e1_rdy", rdy, 1);
    check("e1_txd", txd, 8'hA5);
    check("e1_count", cnt, 0);
    drain();
    check("a5_rx", rx.size() == 1 ? rx[0] : 32'hFFFF, 8'hA5);
    check("a5_idle", idle, 1);

    // burst of 16 bytes
    rx.delete(); n_rdy = 0; n_done = 0; fs = 0; os = 0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); cycle();
      fs |= full; os |= ovf;
    end
    wr_en = 1'b0;
    drain();
    check("burst_no_full", fs, 0);
    check("burst_no_ovf", os, 0);
    check("burst_rx_n", rx.size(), 16);
    for (int i = 0; i < 16 && i < rx.size(); i++) check("burst_order", rx[i], i);
    check("burst_rdy_done", n_rdy, n_done);

    // stalled serializer: fill and overflow
    stall = 1; cycle();
    for (int i = 1; i <= 20; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom); cycle();
      if (i == 16) begin check("stall_full", full, 1); check("stall_cnt16", cnt, 16); end
      if (i > 16) begin check("stall_ovf", ovf, 1); check("stall_cnt", cnt, 16); end
    end
    wr_en = 1'b0; cycle();
    check("ovf_clear", ovf, 0);
    // pop while full with a write in the same cycle
    stall = 0; cycle();
    wr_en = 1'b1; wr_data = 8'h11; cycle(); wr_en = 1'b0;
    check("fullpop_cnt", cnt, 15);
    check("fullpop_ovf", ovf, 1);
    check("fullpop_rdy", rdy, 1);
    drain();

    // pop and write together at count 3
    stall = 1; cycle();
    for (int i = 0; i < 3; i++) begin wr_en = 1'b1; wr_data = 8'(8'h40 + i); cycle(); end
    wr_en = 1'b0;
    check("c3_pre", cnt, 3);
    stall = 0; cycle();
    wr_en = 1'b1; wr_data = 8'h55; cycle(); wr_en = 1'b0;
    check("c3_cnt", cnt, 3);
    check("c3_rdy", rdy, 1);
    check("c3_txd", txd, 8'h40);
    drain();

    // reset during the second of four bytes
    n_rdy = 0;
    for (int i = 0; i < 4; i++) begin wr_en = 1'b1; wr_data = 8'(8'h80 + i); cycle(); end
    wr_en = 1'b0;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (n_rdy == 2 && resp == 2) begin ok = 1; break; end
      cycle();
    end
    check("mid_wait", ok, 1);
    rst_in = 1'b1; cycle(); rst_in = 1'b0;
    check("mr_count", cnt, 0);
    check("mr_empty", empty, 1);
    check("mr_idle", idle, 1);
    check("mr_txd", txd, 0);
    check("mr_rdy", rdy, 0);
    r0 = n_rdy;
    for (int i = 0; i < 10; i++) cycle();
    check("mr_no_rdy", n_rdy, r0);
    rx.delete();
    wr_en = 1'b1; wr_data = 8'h3C; cycle(); wr_en = 1'b0;
    drain();
    check("mr_3c", rx.size() == 1 ? rx[0] : 32'hFFFF, 8'h3C);

    // randomized traffic at several write densities
    for (int c = 0; c < 4; c++) begin
      int p;
      p = (c == 0) ? 90 : (c == 1) ? 30 : (c == 2) ? 60 : 100;
      for (int i = 0; i < 200; i++) begin
        wr_en = ($urandom_range(0, 99) < p);
        wr_data = 8'($urandom);
        cycle();
      end
      wr_en = 1'b0;
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
